// File: rtl/key_pulse_conditioner.sv
// rtl/key_pulse_conditioner.sv - debounced, auto-repeating step pulses from an active-low key
// One shared counter serves the press/release debounce and both repeat timers.
module key_pulse_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic step_o,
  output logic pressed_o
);

  localparam int unsigned MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int unsigned CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_HELD,
    ST_REPEAT,
    ST_RELEASE_DB
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sync1_q;
  logic             sync2_q;
  logic             step_q;
  logic             pressed_q;
  logic             key;

  // Both synchronizer stages reset to the released level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign key = ~sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      step_q    <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (key) begin
            state_q <= ST_PRESS_DB;
            cnt_q   <= '0;
          end
        end
        ST_PRESS_DB: begin
          if (!key) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q   <= ST_HELD;
            cnt_q     <= '0;
            step_q    <= 1'b1;
            pressed_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        // With repeat disabled the counter simply parks here.
        ST_HELD: begin
          if (!key) begin
            state_q <= ST_RELEASE_DB;
            cnt_q   <= '0;
          end else if (REPEAT_EN && (cnt_q == RD_LAST)) begin
            state_q <= ST_REPEAT;
            cnt_q   <= '0;
            step_q  <= 1'b1;
          end else if (REPEAT_EN) begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_REPEAT: begin
          if (!key) begin
            state_q <= ST_RELEASE_DB;
            cnt_q   <= '0;
          end else if (cnt_q == RP_LAST) begin
            cnt_q  <= '0;
            step_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_RELEASE_DB: begin
          if (key) begin
            state_q <= ST_HELD;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          pressed_q <= 1'b0;
        end
      endcase
    end
  end

  assign step_o    = step_q;
  assign pressed_o = pressed_q;

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// tb/tb_key_pulse_conditioner.sv - bench for key_pulse_conditioner, repeat off (u0) and on (u1)
// Reference model works on run lengths of the two-cycle-delayed key level.
module tb_key_pulse_conditioner;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_n = 1'b1;
  logic step0, pressed0, step1, pressed1;

  always #5 clk = ~clk;

  key_pulse_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u0 (
    .clk_i(clk), .rst_i(rst), .key_n_i(key_n), .step_o(step0), .pressed_o(pressed0));

  key_pulse_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u1 (
    .clk_i(clk), .rst_i(rst), .key_n_i(key_n), .step_o(step1), .pressed_o(pressed1));

  int checks = 0;
  int passes = 0;

  bit dl0 = 1'b1;
  bit dl1 = 1'b1;
  bit m_pressed[2];
  int m_run[2];
  int m_anchor[2];
  bit m_step[2];
  int t = 0;
  bit prev0 = 1'b0;
  bit prev1 = 1'b0;

  typedef struct {
    bit kn;
    bit r;
    bit es;
    bit ep;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // A level change is accepted after D+1 consecutive disagreeing samples; while held,
  // repeats fall at anchor+RD, anchor+RD+RP, ... where anchor is the last entry to the held level.
  task automatic model_edge(input bit kn, input bit r);
    bit k;
    if (r) begin
      dl0 = 1'b1;
      dl1 = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_pressed[i] = 1'b0;
        m_run[i]     = 0;
        m_step[i]    = 1'b0;
      end
    end else begin
      k   = ~dl1;
      dl1 = dl0;
      dl0 = kn;
      for (int i = 0; i < 2; i++) begin
        m_step[i] = 1'b0;
        if (!m_pressed[i]) begin
          if (k) begin
            m_run[i]++;
            if (m_run[i] == D + 1) begin
              m_pressed[i] = 1'b1;
              m_run[i]     = 0;
              m_step[i]    = 1'b1;
              m_anchor[i]  = t;
            end
          end else begin
            m_run[i] = 0;
          end
        end else if (!k) begin
          m_run[i]++;
          if (m_run[i] == D + 1) begin
            m_pressed[i] = 1'b0;
            m_run[i]     = 0;
          end
        end else if (m_run[i] > 0) begin
          m_run[i]    = 0;
          m_anchor[i] = t;
        end else if (i == 1 && (t - m_anchor[i]) >= RD && ((t - m_anchor[i] - RD) % RP) == 0) begin
          m_step[i] = 1'b1;
        end
      end
    end
    t++;
  endtask

  task automatic cycle(input bit kn, input bit r);
    key_n = kn;
    rst   = r;
    @(posedge clk);
    model_edge(kn, r);
    #1;
    check("model_step_u0", int'(step0), int'(m_step[0]));
    check("model_pressed_u0", int'(pressed0), int'(m_pressed[0]));
    check("model_step_u1", int'(step1), int'(m_step[1]));
    check("model_pressed_u1", int'(pressed1), int'(m_pressed[1]));
    check("step_gap_u0", int'(step0 & prev0), 0);
    check("step_gap_u1", int'(step1 & prev1), 0);
    prev0 = step0;
    prev1 = step1;
  endtask

  task automatic push_vec(input bit kn, input bit r, input bit es, input bit ep);
    vec_t v;
    v.kn = kn; v.r = r; v.es = es; v.ep = ep;
    tbl.push_back(v);
  endtask

  task automatic check_list(input string name, input int got[$], input int exp[$]);
    check({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
  endtask

  initial begin
    int got[$];
    int exp[$];
    int lvl;
    int len;

    // Directed table against u0 (repeat disabled).
    push_vec(1, 1, 0, 0);
    push_vec(1, 1, 0, 0);
    for (int i = 0; i < 20; i++) push_vec(1, 0, 0, 0);
    for (int i = 0; i < 8; i++)  push_vec(0, 0, i == 6, i >= 6);
    for (int i = 0; i < 8; i++)  push_vec(1, 0, 0, i < 6);
    push_vec(0, 0, 0, 0); push_vec(0, 0, 0, 0); push_vec(1, 0, 0, 0);
    push_vec(0, 0, 0, 0); push_vec(0, 0, 0, 0); push_vec(0, 0, 0, 0);
    push_vec(1, 0, 0, 0);
    for (int i = 0; i < 8; i++)  push_vec(0, 0, i == 6, i >= 6);
    for (int i = 0; i < 8; i++)  push_vec(1, 0, 0, i < 6);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].kn, tbl[i].r);
      check($sformatf("tbl_step[%0d]", i), int'(step0), int'(tbl[i].es));
      check($sformatf("tbl_pressed[%0d]", i), int'(pressed0), int'(tbl[i].ep));
    end

    // Auto-repeat on u1, then release.
    cycle(1, 1);
    got = {};
    for (int i = 0; i < 24; i++) begin
      cycle(0, 0);
      if (step1) got.push_back(i);
    end
    exp = '{6, 14, 17, 20, 23};
    check_list("repeat_steps", got, exp);
    got = {};
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0);
      if (step1) got.push_back(i);
      check($sformatf("release_pressed[%0d]", i), int'(pressed1), int'(i < 6));
    end
    exp = {};
    check_list("release_steps", got, exp);

    // Release bounce while held restarts the repeat delay.
    cycle(1, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0);
    got = {};
    for (int j = 0; j < 15; j++) begin
      cycle((j < 2) ? 1'b1 : 1'b0, 0);
      if (step1) got.push_back(j);
      check($sformatf("bounce_pressed[%0d]", j), int'(pressed1), 1);
    end
    exp = '{12};
    check_list("bounce_steps", got, exp);

    // Reset during REPEAT with the key still held.
    cycle(0, 1);
    check("reset_step", int'(step1), 0);
    check("reset_pressed", int'(pressed1), 0);
    got = {};
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0);
      if (step1) got.push_back(i);
    end
    exp = '{6};
    check_list("post_reset_steps", got, exp);

    // Randomized runs of key level with occasional resets.
    for (int b = 0; b < 220; b++) begin
      lvl = $urandom_range(0, 1);
      len = $urandom_range(1, 14);
      if ($urandom_range(0, 39) == 0) cycle(lvl[0], 1);
      for (int c = 0; c < len; c++) cycle(lvl[0], 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/key_pulse_conditioner.md
# key_pulse_conditioner

Conditions the raw active-low pushbutton (KEY) into clean, single-cycle step pulses for the mod-ten counter stage that drives the HEX digit decoder. It synchronizes the asynchronous key, debounces press and release, emits exactly one `Step` per debounced press, and optionally auto-repeats while the key is held. It sits directly upstream of the counter, on the same system clock.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronized samples required to accept a press or a release (10 ms at 50 MHz); must be ≥1.
- `REPEAT_EN`, default 1: 1 enables auto-repeat while held; 0 disables it.
- `REPEAT_DELAY`, default 25000000: cycles from the first `Step` to the first repeat `Step`; must be ≥1.
- `REPEAT_PERIOD`, default 10000000: cycles between subsequent repeat `Step`s; must be ≥1.
- `Clock` input 1: system clock; all logic is on the rising edge.
- `Reset` input 1: synchronous, active-high reset.
- `KeyN` input 1: raw pushbutton, active-low (0 = pressed), asynchronous and bouncy.
- `Step` output 1: registered one-cycle pulse; one pulse per accepted press or repeat.
- `Pressed` output 1: registered debounced key level (1 = held).

## Operation
- Synchronizer: two flops on `KeyN`, both reset to 1 (released). Internal `k = ~sync2`.
- One shared cycle counter. Its width is the clog2 of the largest parameter. It clears on every state transition.
- States and transitions:
  - IDLE, with `Pressed`=0. If `k`=1, go to PRESS_DB.
  - PRESS_DB, with `Pressed`=0. If `k`=0, return to IDLE (bounce rejected, no `Step`). If `k`=1 and the counter reaches DEBOUNCE_CYCLES−1, go to HELD and assert `Step`. Otherwise increment the counter.
  - HELD, with `Pressed`=1. If `k`=0, go to RELEASE_DB. If REPEAT_EN=1 and the counter reaches REPEAT_DELAY−1, go to REPEAT and assert `Step`.
  - REPEAT, with `Pressed`=1. If `k`=0, go to RELEASE_DB. Each time the counter reaches REPEAT_PERIOD−1, pulse `Step` and wrap the counter to 0.
  - RELEASE_DB, with `Pressed`=1. If `k`=1, return to HELD with no `Step`; the repeat delay restarts. After DEBOUNCE_CYCLES consecutive `k`=0 samples, go to IDLE.
- `Step` and `Pressed` are registered decodes of the next state and transition. No combinational path exists from `KeyN`.
- `Step` is never high for two consecutive cycles.
- Reset priority: `Reset` overrides all transitions in the same cycle.
- Reset values: state IDLE, counter 0, sync flops 1, `Step`=0, `Pressed`=0.
- Reset mid-operation:
  - No `Step` is produced on the reset cycle or the cycle after.
  - If the key is still held when `Reset` drops, it is treated as a new press. A full debounce is required, followed by one `Step`.

## Timing
- Edge numbering: edge 0 is the first rising edge that samples `KeyN`=0.
- `sync2` reflects the new level after edge 1, and the FSM reacts at edge 2.
- Press latency: `Step` and `Pressed` go high after edge D+2, where D = DEBOUNCE_CYCLES. `Step` stays high one cycle; `Pressed` stays high until release completes.
- Repeat timing:
  - The first repeat `Step` occurs REPEAT_DELAY cycles after the first `Step`.
  - Later repeats occur every REPEAT_PERIOD cycles.
- Release latency: with edge 0 as the first edge sampling `KeyN`=1, `Pressed` falls after edge D+2.
- Bounce rejection: any glitch whose synchronized width is less than D cycles produces no `Step` and no `Pressed` change.
- A release bounce in RELEASE_DB never generates a `Step`.
- Throughput: minimum distance between two non-repeat `Step`s is 2D+2 cycles (press, release, press).

## Test plan
All scenarios use D=4, REPEAT_DELAY=8, REPEAT_PERIOD=3 unless noted.
- Reset, then `KeyN`=1 for 20 cycles -> `Step`=0 and `Pressed`=0 throughout.
- `KeyN`=0 held for 8 cycles with REPEAT_EN=0 -> `Step` high exactly one cycle, after edge 6; `Pressed`=1 from edge 6 onward. Then release -> `Pressed`=0 after release edge 6.
- Press bounce: `KeyN` sequence 0,0,1,0,0,0,1, then 0 held -> no `Step` during the bounce; exactly one `Step` 6 edges after the final stable 0.
- Auto-repeat, `KeyN`=0 held for 25 cycles -> `Step` after edges 6, 14, 17, 20, 23. Release -> no further `Step`; `Pressed` falls 6 edges after release.
- Release bounce: while in HELD, `KeyN` goes 1,1,0, then stays 0 -> `Pressed` stays 1, no `Step`; the repeat delay restarts, giving the next `Step` 8 cycles after re-entering HELD.
- Reset asserted during REPEAT with the key still held -> `Step`=0 and `Pressed`=0 on the next edge. After `Reset` drops, exactly one `Step` follows 6 edges later.
